// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS independent BCD mm:ss alarm slots, each with its own
// IDLE/ARMED/RINGING/SNOOZE state machine driven by the running clock digits.
// Status outputs are decoded directly from the registered slot states.
module alarm_bank #(
    parameter int  NUM_ALARMS   = 4,
    parameter int  SNOOZE_SEC   = 9,
    parameter int  RING_TIMEOUT = 60,
    localparam int IDW          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_oneSecStrb,
    input  logic                  i_oneSecPluse,
    input  logic [15:0]           i_time,
    input  logic                  ld_en,
    input  logic [IDW-1:0]        ld_sel,
    input  logic [1:0]            ld_digit,
    input  logic [3:0]            ld_num,
    input  logic                  en_set,
    input  logic                  en_clr,
    input  logic                  snooze,
    input  logic                  ack,
    input  logic [IDW-1:0]        rd_sel,
    output logic [15:0]           o_alarm_time,
    output logic [NUM_ALARMS-1:0] o_armed,
    output logic                  o_ring,
    output logic [IDW-1:0]        o_ring_id,
    output logic                  o_snoozing,
    output logic                  o_blink
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RING  = 2'd2,
        S_SNZ   = 2'd3
    } state_t;

    localparam logic [7:0] SNOOZE_LD = 8'(SNOOZE_SEC);
    localparam logic [7:0] RING_MAX  = 8'(RING_TIMEOUT);

    state_t      state_q    [NUM_ALARMS];
    state_t      state_d    [NUM_ALARMS];
    logic [7:0]  ring_cnt_q [NUM_ALARMS];
    logic [7:0]  ring_cnt_d [NUM_ALARMS];
    logic [7:0]  snz_cnt_q  [NUM_ALARMS];
    logic [7:0]  snz_cnt_d  [NUM_ALARMS];
    logic [15:0] alarm_q    [NUM_ALARMS];
    logic [15:0] alarm_d    [NUM_ALARMS];
    logic [15:0] time_q;

    logic [NUM_ALARMS-1:0] slot_hit;
    logic [NUM_ALARMS-1:0] tick_match;
    logic                  time_chg;
    logic                  digit_ok;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'h00) ? v : v - 8'd1;
    endfunction

    // Decode command addressing, digit legality and edge-qualified time match
    always_comb begin
        time_chg = (i_time != time_q);
        // Odd digit positions are tens digits (max 5), even are ones (max 9)
        digit_ok = ld_digit[0] ? (ld_num <= 4'd5) : (ld_num <= 4'd9);
        for (int k = 0; k < NUM_ALARMS; k++) begin
            slot_hit[k]   = (int'(ld_sel) == k);
            tick_match[k] = time_chg && (i_time == alarm_q[k]);
        end
    end

    // Next state of every slot: FSM with ack > snooze > en_clr > en_set > counting
    always_comb begin
        for (int k = 0; k < NUM_ALARMS; k++) begin
            state_d[k]    = state_q[k];
            ring_cnt_d[k] = ring_cnt_q[k];
            snz_cnt_d[k]  = snz_cnt_q[k];
            alarm_d[k]    = alarm_q[k];

            if (ack && (state_q[k] == S_RING || state_q[k] == S_SNZ)) begin
                state_d[k] = S_ARMED;
            end else if (snooze && state_q[k] == S_RING) begin
                state_d[k]   = S_SNZ;
                snz_cnt_d[k] = SNOOZE_LD;
            end else if (en_clr && slot_hit[k]) begin
                state_d[k] = S_IDLE;
            end else if (en_set && slot_hit[k] && state_q[k] == S_IDLE) begin
                state_d[k] = S_ARMED;
            end else begin
                case (state_q[k])
                    S_ARMED: begin
                        if (tick_match[k]) begin
                            state_d[k]    = S_RING;
                            ring_cnt_d[k] = 8'd0;
                        end
                    end
                    S_RING: begin
                        if (i_oneSecStrb) begin
                            ring_cnt_d[k] = sat_inc(ring_cnt_q[k]);
                            if (sat_inc(ring_cnt_q[k]) >= RING_MAX) begin
                                state_d[k] = S_ARMED;
                            end
                        end
                    end
                    S_SNZ: begin
                        if (i_oneSecStrb) begin
                            snz_cnt_d[k] = sat_dec(snz_cnt_q[k]);
                            if (sat_dec(snz_cnt_q[k]) == 8'd0) begin
                                state_d[k]    = S_RING;
                                ring_cnt_d[k] = 8'd0;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Digit writes are independent of the FSM
            if (ld_en && slot_hit[k] && digit_ok) begin
                alarm_d[k][{ld_digit, 2'b00} +: 4] = ld_num;
            end
        end
    end

    // Status decode; scanning high-to-low leaves the lowest ringing index
    always_comb begin
        o_armed      = '0;
        o_ring       = 1'b0;
        o_ring_id    = '0;
        o_snoozing   = 1'b0;
        o_alarm_time = 16'h0000;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            o_armed[k] = (state_q[k] != S_IDLE);
            if (state_q[k] == S_RING) begin
                o_ring    = 1'b1;
                o_ring_id = IDW'(k);
            end
            if (state_q[k] == S_SNZ) begin
                o_snoozing = 1'b1;
            end
            if (int'(rd_sel) == k) begin
                o_alarm_time = alarm_q[k];
            end
        end
        o_blink = o_ring & i_oneSecPluse;
    end

    // Slot state, counters, alarm times and previous clock value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q <= 16'h0000;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                state_q[k]    <= S_IDLE;
                ring_cnt_q[k] <= 8'd0;
                snz_cnt_q[k]  <= 8'd0;
                alarm_q[k]    <= 16'h0000;
            end
        end else begin
            time_q <= i_time;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                state_q[k]    <= state_d[k];
                ring_cnt_q[k] <= ring_cnt_d[k];
                snz_cnt_q[k]  <= snz_cnt_d[k];
                alarm_q[k]    <= alarm_d[k];
            end
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Testbench for alarm_bank: directed scenarios plus a randomized run checked
// against a behavioural model of the alarm slots.
module tb_alarm_bank;

    localparam int N    = 4;
    localparam int SNZN = 9;
    localparam int RTO  = 60;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    logic        clk = 1'b0;
    logic        rst, rst_s;
    logic        i_oneSecStrb, i_oneSecPluse;
    logic [15:0] i_time;
    logic        ld_en, en_set, en_clr, snooze, ack;
    logic [1:0]  ld_sel, ld_digit, rd_sel;
    logic [3:0]  ld_num;

    logic [15:0] o_alarm_time, s_alarm_time;
    logic [3:0]  o_armed;
    logic [2:0]  s_armed;
    logic        o_ring, o_snoozing, o_blink, s_ring, s_snoozing, s_blink;
    logic [1:0]  o_ring_id, s_ring_id;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: per-slot mode, seconds rung, snooze seconds left
    int          m_st [N];
    int          m_rc [N];
    int          m_sc [N];
    logic [15:0] m_al [N];
    logic [15:0] m_tp;

    always #5 clk = ~clk;

    alarm_bank u_dut (
        .clk(clk), .rst(rst), .i_oneSecStrb(i_oneSecStrb), .i_oneSecPluse(i_oneSecPluse),
        .i_time(i_time), .ld_en(ld_en), .ld_sel(ld_sel), .ld_digit(ld_digit), .ld_num(ld_num),
        .en_set(en_set), .en_clr(en_clr), .snooze(snooze), .ack(ack), .rd_sel(rd_sel),
        .o_alarm_time(o_alarm_time), .o_armed(o_armed), .o_ring(o_ring),
        .o_ring_id(o_ring_id), .o_snoozing(o_snoozing), .o_blink(o_blink)
    );

    alarm_bank #(.NUM_ALARMS(3)) u_small (
        .clk(clk), .rst(rst_s), .i_oneSecStrb(i_oneSecStrb), .i_oneSecPluse(i_oneSecPluse),
        .i_time(i_time), .ld_en(ld_en), .ld_sel(ld_sel), .ld_digit(ld_digit), .ld_num(ld_num),
        .en_set(en_set), .en_clr(en_clr), .snooze(snooze), .ack(ack), .rd_sel(rd_sel),
        .o_alarm_time(s_alarm_time), .o_armed(s_armed), .o_ring(s_ring),
        .o_ring_id(s_ring_id), .o_snoozing(s_snoozing), .o_blink(s_blink)
    );

    function automatic logic [15:0] tm(int m, int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_st[k] = M_IDLE; m_rc[k] = 0; m_sc[k] = 0; m_al[k] = 16'h0000;
        end
        m_tp = 16'h0000;
    endtask

    // Apply one clock's worth of the alarm rules to the model
    task automatic model_update();
        bit changed, legal;
        int base;
        changed = (i_time != m_tp);
        for (int k = 0; k < N; k++) begin
            bit hit, match;
            hit   = (int'(ld_sel) == k);
            match = changed && (i_time == m_al[k]);
            if (ack && (m_st[k] == M_RING || m_st[k] == M_SNZ)) m_st[k] = M_ARMED;
            else if (snooze && m_st[k] == M_RING) begin m_st[k] = M_SNZ; m_sc[k] = SNZN; end
            else if (en_clr && hit) m_st[k] = M_IDLE;
            else if (en_set && hit && m_st[k] == M_IDLE) m_st[k] = M_ARMED;
            else if (m_st[k] == M_ARMED && match) begin m_st[k] = M_RING; m_rc[k] = 0; end
            else if (m_st[k] == M_RING && i_oneSecStrb) begin
                m_rc[k]++;
                if (m_rc[k] >= RTO) m_st[k] = M_ARMED;
            end else if (m_st[k] == M_SNZ && i_oneSecStrb) begin
                m_sc[k]--;
                if (m_sc[k] <= 0) begin m_st[k] = M_RING; m_rc[k] = 0; end
            end
        end
        legal = (ld_digit == 2'd1 || ld_digit == 2'd3) ? (ld_num < 6) : (ld_num < 10);
        if (ld_en && legal && int'(ld_sel) < N) begin
            base = int'(ld_digit) * 4;
            m_al[ld_sel][base +: 4] = ld_num;
        end
        m_tp = i_time;
    endtask

    function automatic bit e_ring();
        for (int k = 0; k < N; k++) if (m_st[k] == M_RING) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] e_id();
        for (int k = 0; k < N; k++) if (m_st[k] == M_RING) return 2'(k);
        return 2'd0;
    endfunction

    function automatic bit e_snz();
        for (int k = 0; k < N; k++) if (m_st[k] == M_SNZ) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] e_armed();
        logic [3:0] v;
        for (int k = 0; k < N; k++) v[k] = (m_st[k] != M_IDLE);
        return v;
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_oneSecStrb = 0; ld_en = 0; en_set = 0; en_clr = 0; snooze = 0; ack = 0;
    endtask

    task automatic ld_slot(input int slot, input logic [15:0] val);
        for (int d = 3; d >= 0; d--) begin
            ld_en = 1; ld_sel = 2'(slot); ld_digit = 2'(d); ld_num = val[d*4 +: 4];
            step();
        end
        ld_en = 0;
    endtask

    task automatic arm(input int slot);
        en_set = 1; ld_sel = 2'(slot); step(); en_set = 0;
    endtask

    task automatic strobe(input int n);
        repeat (n) begin
            i_oneSecStrb = 1; step(); i_oneSecStrb = 0; step();
        end
    endtask

    task automatic test_reset();
        rst = 1; rst_s = 1; idle_in(); i_oneSecPluse = 0; i_time = 16'h0000;
        ld_sel = 0; ld_digit = 0; ld_num = 0; rd_sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_ring !== 1'b0 || o_armed !== 4'b0000 || o_snoozing !== 1'b0 || o_ring_id !== 2'd0)
            begin errors++; $display("FAIL reset_status got ring=%0b armed=%b snz=%0b id=%0d exp all 0", o_ring, o_armed, o_snoozing, o_ring_id); end
        checks++; if (o_alarm_time !== 16'h0000 || o_blink !== 1'b0)
            begin errors++; $display("FAIL reset_time got %h blink=%0b exp 0000 0", o_alarm_time, o_blink); end
        rst = 0;
        ld_slot(0, tm(0, 5));
        arm(0);
        i_time = tm(0, 4); step();
        i_time = tm(0, 5); step();
        checks++; if (o_ring !== 1'b1)
            begin errors++; $display("FAIL reset_prering got %0b exp 1", o_ring); end
        #2 rst = 1;
        #1;
        checks++; if (o_ring !== 1'b0 || o_armed !== 4'b0000 || o_alarm_time !== 16'h0000)
            begin errors++; $display("FAIL reset_async got ring=%0b armed=%b time=%h exp 0 0000 0000", o_ring, o_armed, o_alarm_time); end
        model_reset();
        rst = 0;
    endtask

    task automatic test_ring_ack();
        ld_slot(2, tm(1, 30));
        arm(2);
        i_time = tm(1, 29); step();
        checks++; if (o_ring !== 1'b0)
            begin errors++; $display("FAIL ra_early got %0b exp 0", o_ring); end
        i_time = tm(1, 30); step();
        checks++; if (o_ring !== 1'b1 || o_ring_id !== 2'd2)
            begin errors++; $display("FAIL ra_ring got ring=%0b id=%0d exp 1 2", o_ring, o_ring_id); end
        i_oneSecPluse = 1; #1;
        checks++; if (o_blink !== 1'b1)
            begin errors++; $display("FAIL ra_blink_hi got %0b exp 1", o_blink); end
        i_oneSecPluse = 0; #1;
        checks++; if (o_blink !== 1'b0)
            begin errors++; $display("FAIL ra_blink_lo got %0b exp 0", o_blink); end
        ack = 1; step(); ack = 0;
        checks++; if (o_ring !== 1'b0 || o_armed[2] !== 1'b1)
            begin errors++; $display("FAIL ra_ack got ring=%0b armed2=%0b exp 0 1", o_ring, o_armed[2]); end
    endtask

    task automatic test_snooze();
        ld_slot(1, tm(2, 45));
        arm(1);
        i_time = tm(2, 44); step();
        i_time = tm(2, 45); step();
        snooze = 1; step(); snooze = 0;
        checks++; if (o_snoozing !== 1'b1 || o_ring !== 1'b0)
            begin errors++; $display("FAIL snz_enter got snz=%0b ring=%0b exp 1 0", o_snoozing, o_ring); end
        strobe(8);
        checks++; if (o_ring !== 1'b0 || o_snoozing !== 1'b1)
            begin errors++; $display("FAIL snz_8 got ring=%0b snz=%0b exp 0 1", o_ring, o_snoozing); end
        strobe(1);
        checks++; if (o_ring !== 1'b1 || o_ring_id !== 2'd1 || o_snoozing !== 1'b0)
            begin errors++; $display("FAIL snz_9 got ring=%0b id=%0d snz=%0b exp 1 1 0", o_ring, o_ring_id, o_snoozing); end
        ack = 1; step(); ack = 0;
    endtask

    task automatic test_timeout_frozen();
        ld_slot(0, tm(3, 10));
        arm(0);
        i_time = tm(3, 9); step();
        i_time = tm(3, 10); step();
        strobe(59);
        checks++; if (o_ring !== 1'b1)
            begin errors++; $display("FAIL to_59 got %0b exp 1", o_ring); end
        strobe(1);
        checks++; if (o_ring !== 1'b0 || o_armed[0] !== 1'b1)
            begin errors++; $display("FAIL to_60 got ring=%0b armed0=%0b exp 0 1", o_ring, o_armed[0]); end
        strobe(5);
        checks++; if (o_ring !== 1'b0)
            begin errors++; $display("FAIL to_frozen got %0b exp 0", o_ring); end
    endtask

    task automatic test_simul_illegal();
        ld_slot(0, tm(2, 0));
        ld_slot(3, tm(2, 0));
        arm(3);
        i_time = tm(1, 59); step();
        i_time = tm(2, 0); step();
        checks++; if (o_ring !== 1'b1 || o_ring_id !== 2'd0)
            begin errors++; $display("FAIL si_both got ring=%0b id=%0d exp 1 0", o_ring, o_ring_id); end
        ack = 1; snooze = 1; step(); ack = 0; snooze = 0;
        checks++; if (o_ring !== 1'b0 || o_snoozing !== 1'b0 || o_armed !== 4'b1111)
            begin errors++; $display("FAIL si_acksnz got ring=%0b snz=%0b armed=%b exp 0 0 1111", o_ring, o_snoozing, o_armed); end
        ld_en = 1; ld_sel = 3; ld_digit = 3; ld_num = 7; step();
        ld_digit = 0; ld_num = 10; step();
        ld_en = 0;
        rd_sel = 3; #1;
        checks++; if (o_alarm_time !== 16'h0200)
            begin errors++; $display("FAIL si_illegal got %h exp 0200", o_alarm_time); end
        i_time = tm(2, 1); step();
        i_time = tm(2, 0); step();
        en_clr = 1; ld_sel = 3; step(); en_clr = 0;
        checks++; if (o_armed !== 4'b0111 || o_ring !== 1'b1 || o_ring_id !== 2'd0)
            begin errors++; $display("FAIL si_clr got armed=%b ring=%0b id=%0d exp 0111 1 0", o_armed, o_ring, o_ring_id); end
        ack = 1; step(); ack = 0;
    endtask

    task automatic test_out_of_range();
        rst_s = 0;
        ld_en = 1; ld_sel = 3; ld_digit = 1; ld_num = 3; step(); ld_en = 0;
        en_set = 1; step(); en_set = 0;
        checks++; if (s_armed !== 3'b000)
            begin errors++; $display("FAIL oor_armed got %b exp 000", s_armed); end
        for (int r = 0; r < 4; r++) begin
            rd_sel = 2'(r); #1;
            checks++; if (s_alarm_time !== 16'h0000)
                begin errors++; $display("FAIL oor_rd%0d got %h exp 0000", r, s_alarm_time); end
        end
        ld_en = 1; ld_sel = 2; ld_digit = 0; ld_num = 4; step(); ld_en = 0;
        en_set = 1; step(); en_set = 0;
        rd_sel = 2; #1;
        checks++; if (s_alarm_time !== 16'h0004 || s_armed !== 3'b100)
            begin errors++; $display("FAIL oor_inrange got %h armed=%b exp 0004 100", s_alarm_time, s_armed); end
        checks++; if (o_armed !== e_armed())
            begin errors++; $display("FAIL oor_main got %b exp %b", o_armed, e_armed()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r == 4 || r == 5) i_time = m_al[$urandom_range(0, N - 1)];
            else if (r == 6) i_time = tm(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
            else if (r == 7) i_time = tm(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
            i_oneSecStrb  = ($urandom_range(0, 2) == 0);
            i_oneSecPluse = 1'($urandom_range(0, 1));
            ld_en    = ($urandom_range(0, 7) == 0);
            en_set   = ($urandom_range(0, 3) == 0);
            en_clr   = ($urandom_range(0, 19) == 0);
            snooze   = ($urandom_range(0, 24) == 0);
            ack      = ($urandom_range(0, 39) == 0);
            ld_sel   = 2'($urandom_range(0, 3));
            ld_digit = 2'($urandom_range(0, 3));
            ld_num   = 4'($urandom_range(0, 15));
            rd_sel   = 2'($urandom_range(0, 3));
            step();
            checks++; if (o_armed !== e_armed())
                begin errors++; $display("FAIL rnd_armed c=%0d got %b exp %b", c, o_armed, e_armed()); end
            checks++; if (o_ring !== e_ring())
                begin errors++; $display("FAIL rnd_ring c=%0d got %0b exp %0b", c, o_ring, e_ring()); end
            checks++; if (o_ring_id !== e_id())
                begin errors++; $display("FAIL rnd_id c=%0d got %0d exp %0d", c, o_ring_id, e_id()); end
            checks++; if (o_snoozing !== e_snz())
                begin errors++; $display("FAIL rnd_snz c=%0d got %0b exp %0b", c, o_snoozing, e_snz()); end
            checks++; if (o_blink !== (e_ring() & i_oneSecPluse))
                begin errors++; $display("FAIL rnd_blink c=%0d got %0b exp %0b", c, o_blink, e_ring() & i_oneSecPluse); end
            checks++; if (o_alarm_time !== m_al[rd_sel])
                begin errors++; $display("FAIL rnd_time c=%0d got %h exp %h", c, o_alarm_time, m_al[rd_sel]); end
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_ring_ack();
        test_snooze();
        test_timeout_frozen();
        test_simul_illegal();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
